axi4_lite_read_pipe: RTL

AXI4_LITE_READ_PIPE -- requirements
Module: axi4_lite_read_pipe

---
 rtl/axi4_lite_read_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi4_lite_read_pipe.sv
// AXI4-Lite read slave: register strobe, fixed-latency pipe, in-order FIFO.
// Define AXI4_LITE_READ_PIPE_ALIGN_CHECK_EN to return SLVERR on misaligned reads.
module axi4_lite_read_pipe #(
  parameter int DEPTH        = 8,
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 16,
  parameter int READ_LATENCY = 2,
  parameter int OUTSTANDING  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_clk_i,
  input  logic [ADDR_SIZE-1:0]     read_address_i,
  input  logic                     read_address_valid_i,
  output logic                     read_address_ready_o,
  output logic [DATA_SIZE-1:0]     read_data_o,
  output logic [1:0]               read_data_response_o,
  output logic                     read_data_valid_o,
  input  logic                     read_data_ready_i,
  output logic [$clog2(DEPTH)-1:0] register_address_o,
  output logic                     register_read_o,
  input  logic [DATA_SIZE-1:0]     register_data_i
);

  localparam int BW = $clog2(DATA_SIZE/8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(OUTSTANDING+1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int L  = READ_LATENCY;

  localparam logic [CW-1:0] OUT_MAX  = CW'(OUTSTANDING);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING-1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [CW-1:0] credit;
  logic          ar_hs;
  logic          r_hs;
  logic [IW-1:0] idx;
  logic          dec_err;
  logic          slv_err;
  logic          hit;
  logic [1:0]    ar_resp;

  assign read_address_ready_o = (credit < OUT_MAX) && !rst_clk_i;
  assign ar_hs   = read_address_valid_i && read_address_ready_o;
  assign idx     = read_address_i[BW +: IW];
  assign dec_err = |read_address_i[ADDR_SIZE-1:BW+IW];

`ifdef AXI4_LITE_READ_PIPE_ALIGN_CHECK_EN
  assign slv_err = !dec_err && (|read_address_i[BW-1:0]);
`else
  // Byte-offset bits are simply dropped; the read uses the truncated index.
  logic unused_low;
  assign unused_low = ^read_address_i[BW-1:0];
  assign slv_err    = 1'b0;
`endif

  assign hit = !dec_err && !slv_err;

  always_comb begin
    ar_resp = RESP_OKAY;
    unique case (1'b1)
      dec_err: ar_resp = RESP_DECERR;
      slv_err: ar_resp = RESP_SLVERR;
      default: ar_resp = RESP_OKAY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      register_read_o    <= 1'b0;
      register_address_o <= '0;
    end else begin
      register_read_o <= ar_hs && hit;
      if (ar_hs && hit)
        register_address_o <= idx;
    end
  end

  logic [L-1:0] pv;
  logic [1:0]   pr [L];

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      pv <= '0;
    end else begin
      pv[0] <= ar_hs;
      for (int i = 1; i < L; i++)
        pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    pr[0] <= ar_resp;
    for (int i = 1; i < L; i++)
      pr[i] <= pr[i-1];
  end

  logic                 push;
  logic [1:0]           push_resp;
  logic [DATA_SIZE-1:0] push_data;

  assign push      = pv[L-1];
  assign push_resp = pr[L-1];
  assign push_data = (push_resp == RESP_OKAY) ? register_data_i : '0;

  logic [DATA_SIZE-1:0] fd [OUTSTANDING];
  logic [1:0]           fr [OUTSTANDING];
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        cnt;

  assign read_data_valid_o    = (cnt != '0);
  assign r_hs                 = read_data_valid_o && read_data_ready_i;
  assign read_data_o          = read_data_valid_o ? fd[rp] : '0;
  assign read_data_response_o = read_data_valid_o ? fr[rp] : RESP_OKAY;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fd[wp] <= push_data;
      fr[wp] <= push_resp;
    end
  end

  // Credit covers pipe plus FIFO, so the FIFO cannot overflow.
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      credit <= '0;
    end else begin
      if (push)
        wp <= (wp == PTR_LAST) ? '0 : wp + PTR_ONE;
      if (r_hs)
        rp <= (rp == PTR_LAST) ? '0 : rp + PTR_ONE;
      unique case ({push, r_hs})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
      unique case ({ar_hs, r_hs})
        2'b10:   credit <= credit + ONE;
        2'b01:   credit <= credit - ONE;
        default: credit <= credit;
      endcase
    end
  end

endmodule
